// File: rtl/qlf_fifo_pkg.sv
// rtl/qlf_fifo_pkg.sv - shared flag-bus indices and width helpers for the qlf FIFO
package qlf_fifo_pkg;

    // Bit positions inside the 8-bit fflags bus, MSB first.
    localparam int FLAG_FULL     = 7;
    localparam int FLAG_FMO      = 6;
    localparam int FLAG_FWM      = 5;
    localparam int FLAG_OVERRUN  = 4;
    localparam int FLAG_EMPTY    = 3;
    localparam int FLAG_EPO      = 2;
    localparam int FLAG_EWM      = 1;
    localparam int FLAG_UNDERRUN = 0;

    localparam int FLAG_BITS = 8;

    // Occupancy needs one extra bit so that 0..DEPTH is representable.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/qlf_fifo_mem.sv
// rtl/qlf_fifo_mem.sv - simple dual-port RAM with one registered read port
module qlf_fifo_mem
    import qlf_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port: contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: output register only updates on a read and clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/qlf_sync_fifo.sv
// rtl/qlf_sync_fifo.sv - parametrised single-clock FIFO with optional FWFT and sticky errors
module qlf_sync_fifo
    import qlf_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int FWFT       = 0,
    parameter int UPAF       = 4,
    parameter int UPAE       = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WEN,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic                    REN,
    output logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    FLUSH,
    input  logic                    CLR_ERR,
    output logic                    EMPTY,
    output logic                    EPO,
    output logic                    EWM,
    output logic                    UNDERRUN,
    output logic                    FULL,
    output logic                    FMO,
    output logic                    FWM,
    output logic                    OVERRUN,
    output logic [ADDR_WIDTH:0]     COUNT
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = cnt_w(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] UPAF_C  = CW'(UPAF);
    localparam logic [CW-1:0] UPAE_C  = CW'(UPAE);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    if (UPAF > DEPTH) begin : g_bad_upaf
        $error("qlf_sync_fifo: UPAF exceeds DEPTH");
    end
    if (UPAE > DEPTH) begin : g_bad_upae
        $error("qlf_sync_fifo: UPAE exceeds DEPTH");
    end

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_nxt;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_nxt;
    logic [CW-1:0]         count_q, count_nxt;
    logic [CW-1:0]         mem_level;
    logic                  valid_q, valid_nxt;
    logic [FLAG_BITS-1:0]  flags_q, flags_nxt;

    logic wr_acc, rd_acc, mem_re;
    logic ovr_set, unr_set, empty_nxt;

    // Level flags for a given occupancy; error bits are filled in separately.
    function automatic logic [FLAG_BITS-1:0] level_flags(input logic [CW-1:0] cnt,
                                                         input logic          empty);
        logic [FLAG_BITS-1:0] f;
        f                = '0;
        f[FLAG_FULL]     = (cnt == DEPTH_C);
        f[FLAG_FMO]      = (cnt == DEPTH_C - ONE_C);
        f[FLAG_FWM]      = ((DEPTH_C - cnt) <= UPAF_C);
        f[FLAG_EMPTY]    = empty;
        f[FLAG_EPO]      = (cnt == ONE_C);
        f[FLAG_EWM]      = (cnt <= UPAE_C);
        return f;
    endfunction

    // Next-state for pointers, occupancy, FWFT head-valid and all registered flags.
    always_comb begin
        wr_acc  = WEN & ~flags_q[FLAG_FULL]  & ~FLUSH;
        rd_acc  = REN & ~flags_q[FLAG_EMPTY] & ~FLUSH;
        ovr_set = WEN &  flags_q[FLAG_FULL]  & ~FLUSH;
        unr_set = REN &  flags_q[FLAG_EMPTY] & ~FLUSH;

        // Words still sitting in RAM; in FWFT the head word lives in the read register.
        mem_level = count_q - CW'(valid_q);

        if (FWFT != 0) begin
            mem_re = ~FLUSH & (mem_level != '0) & (~valid_q | rd_acc);
        end else begin
            mem_re = rd_acc;
        end

        valid_nxt = valid_q;
        if (FWFT != 0) begin
            if (mem_re) begin
                valid_nxt = 1'b1;
            end else if (rd_acc) begin
                valid_nxt = 1'b0;
            end
        end

        count_nxt = count_q;
        if (wr_acc && !rd_acc) begin
            count_nxt = count_q + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - ONE_C;
        end

        waddr_nxt = wr_acc ? waddr_q + ADDR_WIDTH'(1) : waddr_q;
        raddr_nxt = mem_re ? raddr_q + ADDR_WIDTH'(1) : raddr_q;

        if (FLUSH) begin
            count_nxt = '0;
            valid_nxt = 1'b0;
            waddr_nxt = '0;
            raddr_nxt = '0;
        end

        empty_nxt = (FWFT != 0) ? ~valid_nxt : (count_nxt == '0);
        flags_nxt = level_flags(count_nxt, empty_nxt);

        // Sticky errors: a new error wins over a clear in the same cycle.
        if (FLUSH) begin
            flags_nxt[FLAG_OVERRUN] = 1'b0;
        end else if (ovr_set) begin
            flags_nxt[FLAG_OVERRUN] = 1'b1;
        end else if (CLR_ERR) begin
            flags_nxt[FLAG_OVERRUN] = 1'b0;
        end else begin
            flags_nxt[FLAG_OVERRUN] = flags_q[FLAG_OVERRUN];
        end

        if (FLUSH) begin
            flags_nxt[FLAG_UNDERRUN] = 1'b0;
        end else if (unr_set) begin
            flags_nxt[FLAG_UNDERRUN] = 1'b1;
        end else if (CLR_ERR) begin
            flags_nxt[FLAG_UNDERRUN] = 1'b0;
        end else begin
            flags_nxt[FLAG_UNDERRUN] = flags_q[FLAG_UNDERRUN];
        end
    end

    // Control state register with reset taking priority over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            waddr_q <= '0;
            raddr_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            flags_q <= level_flags('0, 1'b1);
        end else begin
            waddr_q <= waddr_nxt;
            raddr_q <= raddr_nxt;
            count_q <= count_nxt;
            valid_q <= valid_nxt;
            flags_q <= flags_nxt;
        end
    end

    qlf_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (CLK),
        .rst   (RST),
        .we    (wr_acc),
        .waddr (waddr_q),
        .wdata (WDATA),
        .re    (mem_re),
        .raddr (raddr_q),
        .rdata (RDATA)
    );

    assign COUNT    = count_q;
    assign FULL     = flags_q[FLAG_FULL];
    assign FMO      = flags_q[FLAG_FMO];
    assign FWM      = flags_q[FLAG_FWM];
    assign OVERRUN  = flags_q[FLAG_OVERRUN];
    assign EMPTY    = flags_q[FLAG_EMPTY];
    assign EPO      = flags_q[FLAG_EPO];
    assign EWM      = flags_q[FLAG_EWM];
    assign UNDERRUN = flags_q[FLAG_UNDERRUN];

endmodule

// File: tb/tb_qlf_sync_fifo.sv
// tb/tb_qlf_sync_fifo.sv - self-checking bench for qlf_sync_fifo in standard and FWFT modes
module tb_qlf_sync_fifo;

    logic       clk;
    logic       rst, wen, ren, flush, clr_err;
    logic [7:0] wdata;

    logic [7:0] rdata0, rdata1;
    logic [3:0] count0, count1;
    logic empty0, epo0, ewm0, unr0, full0, fmo0, fwm0, ovr0;
    logic empty1, epo1, ewm1, unr1, full1, fmo1, fwm1, ovr1;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per DUT (index 0 = standard, 1 = FWFT).
    logic [7:0] mq [2][$];
    logic       vis   [2];
    logic [7:0] rd_e  [2];
    logic       ovr_e [2];
    logic       unr_e [2];

    logic [7:0] r0_hold, r1_hold;

    qlf_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0), .UPAF(2), .UPAE(2)) dut0 (
        .CLK(clk), .RST(rst), .WEN(wen), .WDATA(wdata), .REN(ren), .RDATA(rdata0),
        .FLUSH(flush), .CLR_ERR(clr_err), .EMPTY(empty0), .EPO(epo0), .EWM(ewm0),
        .UNDERRUN(unr0), .FULL(full0), .FMO(fmo0), .FWM(fwm0), .OVERRUN(ovr0), .COUNT(count0)
    );

    qlf_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .UPAF(2), .UPAE(2)) dut1 (
        .CLK(clk), .RST(rst), .WEN(wen), .WDATA(wdata), .REN(ren), .RDATA(rdata1),
        .FLUSH(flush), .CLR_ERR(clr_err), .EMPTY(empty1), .EPO(epo1), .EWM(ewm1),
        .UNDERRUN(unr1), .FULL(full1), .FMO(fmo1), .FWM(fwm1), .OVERRUN(ovr1), .COUNT(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        logic       empty_b, full_b, do_rd, do_wr, vis_n;
        logic [7:0] popped;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mq[m].delete();
                vis[m] = 1'b0; rd_e[m] = 8'h00; ovr_e[m] = 1'b0; unr_e[m] = 1'b0;
            end else if (flush) begin
                mq[m].delete();
                vis[m] = 1'b0; ovr_e[m] = 1'b0; unr_e[m] = 1'b0;
            end else begin
                empty_b = (m == 1) ? !vis[m] : (mq[m].size() == 0);
                full_b  = (mq[m].size() == 8);
                do_rd   = ren && !empty_b;
                do_wr   = wen && !full_b;
                if (wen && full_b) ovr_e[m] = 1'b1;
                else if (clr_err)  ovr_e[m] = 1'b0;
                if (ren && empty_b) unr_e[m] = 1'b1;
                else if (clr_err)   unr_e[m] = 1'b0;
                if (do_rd) begin
                    popped = mq[m].pop_front();
                    if (m == 0) rd_e[m] = popped;
                end
                // A word can be presented only if it was stored before this edge.
                vis_n = (mq[m].size() > 0);
                if (do_wr) mq[m].push_back(wdata);
                if (m == 1) begin
                    vis[m] = vis_n;
                    if (vis_n) rd_e[m] = mq[m][0];
                end
            end
        end
    endtask

    function automatic logic [19:0] exp_vec(input int m);
        int   c;
        logic e;
        c = mq[m].size();
        e = (m == 1) ? !vis[m] : (c == 0);
        return {e, c == 1, c <= 2, unr_e[m], c == 8, c == 7, (8 - c) <= 2, ovr_e[m],
                4'(c), rd_e[m]};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("std_state", {empty0, epo0, ewm0, unr0, full0, fmo0, fwm0, ovr0, count0, rdata0},
            exp_vec(0));
        chk("fwft_state", {empty1, epo1, ewm1, unr1, full1, fmo1, fwm1, ovr1, count1, rdata1},
            exp_vec(1));
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        step();
        rst = 1'b0;
        chk("reset_flags0", {empty0, epo0, ewm0, unr0, full0, fmo0, fwm0, ovr0}, 8'b1010_0000);
        chk("reset_flags1", {empty1, epo1, ewm1, unr1, full1, fmo1, fwm1, ovr1}, 8'b1010_0000);
        chk("reset_count0", count0, 0);
        chk("reset_rdata0", rdata0, 0);

        // Fill: thresholds cross at fixed levels.
        for (int i = 1; i <= 8; i++) begin
            wen = 1'b1; wdata = 8'(i);
            step();
            chk("fill_count", count0, i);
            chk("fill_ewm", ewm0, i <= 2);
            chk("fill_fwm", fwm0, i >= 6);
            chk("fill_fmo", fmo0, i == 7);
            chk("fill_full", full0, i == 8);
        end
        wdata = 8'hFF;
        step();
        chk("overrun_set", ovr0, 1);
        chk("overrun_count", count0, 8);
        clr_err = 1'b1;
        step();
        chk("overrun_set_wins", ovr0, 1);
        wen = 1'b0;
        step();
        chk("overrun_cleared", ovr0, 0);
        clr_err = 1'b0;

        // Drain with one-cycle read latency.
        for (int i = 1; i <= 8; i++) begin
            ren = 1'b1;
            step();
            chk("drain_rdata", rdata0, i);
        end
        chk("drain_empty", empty0, 1);
        step();
        chk("underrun_set", unr0, 1);
        chk("underrun_rdata_hold", rdata0, 8'h08);
        ren = 1'b0; clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Wrap-around: pointers start at 0 again only after passing DEPTH-1.
        for (int i = 0; i < 5; i++) begin
            wen = 1'b1; wdata = 8'(8'h10 + i);
            step();
        end
        wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ren = 1'b1;
            step();
            chk("wrap_rdata", rdata0, 8'h10 + i);
        end
        ren = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1; wdata = 8'(8'h20 + i);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            wen = 1'b1; ren = 1'b1; wdata = 8'(8'h30 + k);
            step();
            chk("simul_count", count0, 2);
            chk("simul_rdata", rdata0, (k < 2) ? 8'h20 + k : 8'h30 + k - 2);
        end
        ren = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1; wdata = 8'(8'h40 + i);
            step();
        end
        chk("pre_flush_count", count0, 4);

        // Flush beats simultaneous requests.
        r0_hold = rdata0; r1_hold = rdata1;
        wen = 1'b1; ren = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; wen = 1'b0; ren = 1'b0;
        chk("flush_count0", count0, 0);
        chk("flush_empty0", empty0, 1);
        chk("flush_errors0", {ovr0, unr0}, 2'b00);
        chk("flush_rdata0", rdata0, r0_hold);
        chk("flush_count1", count1, 0);
        chk("flush_empty1", empty1, 1);
        chk("flush_rdata1", rdata1, r1_hold);

        // FWFT latency and pop behaviour.
        wen = 1'b1; wdata = 8'hA5;
        step();
        wen = 1'b0;
        chk("fwft_not_yet", empty1, 1);
        step();
        chk("fwft_visible", empty1, 0);
        chk("fwft_head", rdata1, 8'hA5);
        wen = 1'b1; wdata = 8'h5A;
        step();
        wen = 1'b0; ren = 1'b1;
        step();
        chk("fwft_next_head", rdata1, 8'h5A);
        chk("fwft_no_bubble", empty1, 0);
        step();
        chk("fwft_last_pop", empty1, 1);
        ren = 1'b0;

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            wen = 1'b1; wdata = 8'(8'h60 + i);
            step();
        end
        chk("pre_reset_count", count0, 3);
        rst = 1'b1; ren = 1'b1;
        step();
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        chk("midrst_std", {empty0, epo0, ewm0, unr0, full0, fmo0, fwm0, ovr0, count0, rdata0},
            {8'b1010_0000, 4'd0, 8'h00});
        chk("midrst_fwft", {empty1, epo1, ewm1, unr1, full1, fmo1, fwm1, ovr1, count1, rdata1},
            {8'b1010_0000, 4'd0, 8'h00});

        // Randomised traffic alternating write-heavy and read-heavy phases.
        for (int n = 0; n < 800; n++) begin
            wen     = ($urandom_range(0, 99) < (((n / 100) % 2 == 0) ? 75 : 30));
            ren     = ($urandom_range(0, 99) < (((n / 100) % 2 == 0) ? 30 : 75));
            wdata   = 8'($urandom);
            flush   = ($urandom_range(0, 99) < 2);
            clr_err = ($urandom_range(0, 99) < 5);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
